// File: rtl/cart_auto_stepper.sv
// Moves a one-hot cart along the LED track, one position per rising edge of the
// divider's automatic-mode clock. The cart bounces at the track ends and stops at stations.
module cart_auto_stepper #(
  parameter int                   TRACK_LEN    = 16,
  parameter logic [TRACK_LEN-1:0] STATION_MASK = 16'h0101,
  parameter int                   DWELL_TICKS  = 24
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 CLK_div_auto,
  input  logic                 ENABLE,
  input  logic                 STOP_REQ,
  output logic [TRACK_LEN-1:0] CART_LED,
  output logic                 DIR,
  output logic                 AT_STATION,
  output logic                 HALTED,
  output logic [1:0]           DBG_STATE
);

  localparam int PW = $clog2(TRACK_LEN);
  localparam logic [PW-1:0] LAST_POS = PW'(TRACK_LEN - 1);
  localparam logic [7:0] DWELL_LOAD = 8'(DWELL_TICKS - 1);
  localparam logic [TRACK_LEN-1:0] LED_AT_ZERO = TRACK_LEN'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MOVE  = 2'd1,
    S_DWELL = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t        state;
  logic [PW-1:0] pos;
  logic [7:0]    dwell_cnt;
  logic          sync1, sync2, edge_q;
  logic          tick;

  logic [PW-1:0]        step_pos;
  logic                 step_dir;
  logic                 station_hit;
  logic [TRACK_LEN-1:0] step_led;

  // The divider output is plain data here: two flops to settle it, one to find its rise.
  assign tick      = sync2 & ~edge_q;
  assign DBG_STATE = state;

  // Candidate position for the next move; the end checks keep it inside the track.
  always_comb begin
    step_pos = pos;
    step_dir = DIR;
    if (DIR) begin
      if (pos != LAST_POS) step_pos = pos + 1'b1;
    end else begin
      if (pos != '0) step_pos = pos - 1'b1;
    end
    if (step_pos == LAST_POS) begin
      step_dir = 1'b0;
    end else if (step_pos == '0) begin
      step_dir = 1'b1;
    end
    station_hit = STATION_MASK[step_pos];
    step_led    = LED_AT_ZERO << step_pos;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= S_IDLE;
      pos        <= '0;
      DIR        <= 1'b1;
      CART_LED   <= LED_AT_ZERO;
      dwell_cnt  <= '0;
      AT_STATION <= 1'b0;
      HALTED     <= 1'b0;
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      edge_q     <= 1'b0;
    end else begin
      sync1  <= CLK_div_auto;
      sync2  <= sync1;
      edge_q <= sync2;
      // An emergency stop beats everything, including a tick on the same cycle.
      if (STOP_REQ) begin
        state      <= S_HALT;
        HALTED     <= 1'b1;
        AT_STATION <= 1'b0;
        dwell_cnt  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (ENABLE) state <= S_MOVE;
          end
          S_MOVE: begin
            if (!ENABLE) begin
              state     <= S_IDLE;
              dwell_cnt <= '0;
            end else if (tick) begin
              pos      <= step_pos;
              DIR      <= step_dir;
              CART_LED <= step_led;
              if (station_hit) begin
                state      <= S_DWELL;
                AT_STATION <= 1'b1;
                dwell_cnt  <= DWELL_LOAD;
              end
            end
          end
          S_DWELL: begin
            // Leaving to IDLE drops the dwell, so a resume departs the station at once.
            if (!ENABLE) begin
              state      <= S_IDLE;
              AT_STATION <= 1'b0;
              dwell_cnt  <= '0;
            end else if (tick) begin
              if (dwell_cnt == '0) begin
                state      <= S_MOVE;
                AT_STATION <= 1'b0;
              end else begin
                dwell_cnt <= dwell_cnt - 1'b1;
              end
            end
          end
          S_HALT: begin
            if (!ENABLE) begin
              state  <= S_IDLE;
              HALTED <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cart_auto_stepper.sv
// Bench for cart_auto_stepper: a per-cycle expected-output queue fed by a reference
// model, drained by a monitor, plus directed checks of latency, bounce, dwell, stop and reset.
module tb_cart_auto_stepper;

  localparam int          L    = 16;
  localparam logic [15:0] MASK = 16'h0101;
  localparam int          DW   = 3;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          CLK_div_auto = 1'b0;
  logic          ENABLE = 1'b0;
  logic          STOP_REQ = 1'b0;
  logic [L-1:0]  CART_LED;
  logic          DIR;
  logic          AT_STATION;
  logic          HALTED;
  logic [1:0]    DBG_STATE;

  cart_auto_stepper #(
    .TRACK_LEN    (L),
    .STATION_MASK (MASK),
    .DWELL_TICKS  (DW)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .CLK_div_auto (CLK_div_auto),
    .ENABLE       (ENABLE),
    .STOP_REQ     (STOP_REQ),
    .CART_LED     (CART_LED),
    .DIR          (DIR),
    .AT_STATION   (AT_STATION),
    .HALTED       (HALTED),
    .DBG_STATE    (DBG_STATE)
  );

  // clock/reset block
  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [20:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 moving, 2 dwelling, 3 halted. The input history
  // h1..h3 holds CLK_div_auto as seen at the previous three edges; a move happens when
  // the value two edges back is 1 and the one three edges back is 0.
  int m_pos, m_dir, m_mode, m_remain;
  bit h1, h2, h3;

  always @(posedge CLK) begin : model
    bit tick;
    if (!RESET) begin
      m_pos = 0; m_dir = 1; m_mode = 0; m_remain = 0;
      h1 = 0; h2 = 0; h3 = 0;
    end else begin
      tick = h2 && !h3;
      if (STOP_REQ) begin
        m_mode = 3;
      end else begin
        case (m_mode)
          0: if (ENABLE) m_mode = 1;
          1: begin
            if (!ENABLE) m_mode = 0;
            else if (tick) begin
              m_pos = m_pos + (m_dir ? 1 : -1);
              if (m_pos == 0 || m_pos == L - 1) m_dir = 1 - m_dir;
              if (((MASK >> m_pos) & 16'h1) != 0) begin
                m_mode   = 2;
                m_remain = DW;
              end
            end
          end
          2: begin
            if (!ENABLE) m_mode = 0;
            else if (tick) begin
              m_remain = m_remain - 1;
              if (m_remain == 0) m_mode = 1;
            end
          end
          default: if (!ENABLE) m_mode = 0;
        endcase
      end
      h3 = h2; h2 = h1; h1 = CLK_div_auto;
    end
    exp_q.push_back({16'(1 << m_pos), m_dir[0], (m_mode == 2), (m_mode == 3), 2'(m_mode)});
  end

  // Monitor: outputs are valid every cycle; compare away from the active edge.
  always @(negedge CLK) begin
    logic [20:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("scoreboard", {CART_LED, DIR, AT_STATION, HALTED, DBG_STATE}, {11'd0, e});
    end
  end

  // Driver tasks: each starts and ends just after a falling edge.
  task automatic give_tick();
    CLK_div_auto = 1'b1;
    repeat (3) @(negedge CLK);
    CLK_div_auto = 1'b0;
    @(negedge CLK);
  endtask

  task automatic give_ticks(input int n);
    for (int i = 0; i < n; i++) give_tick();
  endtask

  initial begin
    RESET = 1'b0;
    repeat (5) @(negedge CLK);
    check("reset_led", CART_LED, 32'h0001);
    check("reset_dir", DIR, 1);
    check("reset_halted", HALTED, 0);
    RESET  = 1'b1;
    ENABLE = 1'b0;
    give_ticks(3);
    check("idle_led", CART_LED, 32'h0001);
    check("idle_state", DBG_STATE, 0);

    ENABLE = 1'b1;
    @(negedge CLK);
    check("move_state", DBG_STATE, 1);
    CLK_div_auto = 1'b1;
    @(posedge CLK); #1 check("latency_edge1", CART_LED, 32'h0001);
    @(posedge CLK); #1 check("latency_edge2", CART_LED, 32'h0001);
    @(posedge CLK); #1 check("latency_edge3", CART_LED, 32'h0002);
    repeat (11) @(negedge CLK);
    check("hold_high", CART_LED, 32'h0002);
    CLK_div_auto = 1'b0;
    @(negedge CLK);

    give_ticks(7);
    check("dwell_arrive_led", CART_LED, 32'h0100);
    check("dwell_arrive_at", AT_STATION, 1);
    for (int i = 0; i < 3; i++) begin
      give_tick();
      check("dwell_hold_led", CART_LED, 32'h0100);
    end
    check("dwell_exit_at", AT_STATION, 0);
    give_tick();
    check("dwell_depart_led", CART_LED, 32'h0200);

    give_ticks(6);
    check("bounce_top_led", CART_LED, 32'h8000);
    check("bounce_top_dir", DIR, 0);
    give_tick();
    check("bounce_back_led", CART_LED, 32'h4000);
    give_ticks(6 + 3 + 8);
    check("bounce_bottom_led", CART_LED, 32'h0001);
    check("bounce_bottom_dir", DIR, 1);
    check("bottom_station_at", AT_STATION, 1);

    give_ticks(3 + 5);
    check("stop_pre_led", CART_LED, 32'h0020);
    CLK_div_auto = 1'b1;
    repeat (2) @(negedge CLK);
    STOP_REQ = 1'b1;
    @(negedge CLK);
    check("stop_led", CART_LED, 32'h0020);
    check("stop_halted", HALTED, 1);
    STOP_REQ     = 1'b0;
    CLK_div_auto = 1'b0;
    repeat (3) @(negedge CLK);
    check("halt_sticky", HALTED, 1);
    ENABLE = 1'b0;
    @(negedge CLK);
    check("halt_exit", HALTED, 0);
    check("halt_exit_state", DBG_STATE, 0);
    ENABLE = 1'b1;
    @(negedge CLK);
    give_tick();
    check("resume_led", CART_LED, 32'h0040);

    give_ticks(2);
    check("pre_reset_at", AT_STATION, 1);
    #2 RESET = 1'b0;
    #1;
    check("async_reset_led", CART_LED, 32'h0001);
    check("async_reset_at", AT_STATION, 0);
    check("async_reset_dir", DIR, 1);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    give_tick();
    check("post_reset_led", CART_LED, 32'h0002);

    // Randomised phase, checked by the scoreboard every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if ($urandom_range(0, 2) == 0) CLK_div_auto = ~CLK_div_auto;
      if ($urandom_range(0, 39) == 0) ENABLE = ~ENABLE;
      STOP_REQ = ($urandom_range(0, 59) == 0);
    end
    STOP_REQ     = 1'b0;
    CLK_div_auto = 1'b0;
    repeat (4) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
